// File: rtl/seq_mult4.sv
// seq_mult4: multi-cycle shift-and-add unsigned multiplier.
// One partial product per clock is added through a WIDTH-stage full-adder
// ripple chain. The 2*WIDTH-bit product is registered and held until the
// next result, and done pulses for one cycle when it updates.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - operand strobe, sampled only in IDLE
//   a, b     - multiplicand / multiplier, captured on an accepted start
//   busy     - high in RUN and DONE
//   done     - one-cycle pulse, product valid
//   product  - registered result
//
// Optional build macro: SEQ_MULT_ZERO_BYPASS_EN. When it is defined, a zero
// operand finishes on the accepting edge and skips RUN entirely.
module seq_mult4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] m_q,       m_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             carry_q,   carry_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [PW-1:0]    product_q, product_d;

    // Ripple-chain signals
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic             zero_byp;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Next-state, adder chain and iteration logic
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        product_d = product_q;
        zero_byp  = 1'b0;

        // Full-adder ripple chain: ACC + (Q[0] ? M : 0). carry_q is the chain
        // carry-in; it is cleared on load and by every shift, so it stays 0.
        addend = q_q[0] ? m_q : '0;
        c[0]   = carry_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]   = acc_q[i] ^ addend[i] ^ c[i];
            c[i+1]   = (acc_q[i] & addend[i]) | (c[i] & (acc_q[i] ^ addend[i]));
        end

`ifdef SEQ_MULT_ZERO_BYPASS_EN
        zero_byp = (a == '0) || (b == '0);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (zero_byp) begin
                        product_d = '0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        m_d     = a;
                        q_d     = b;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Shift {cout, sum, Q} right by one; cout lands in the ACC MSB
                acc_d   = {c[WIDTH], sum[WIDTH-1:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                carry_d = 1'b0;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = {acc_d, q_d};
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
